// File: rtl/prog_delay_line_if.sv
// Stream, configuration and status signals of the programmable delay line.
// The master side drives samples and configuration. The slave side (the delay
// line) returns the delayed stream and its status.
interface prog_delay_line_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16,
    parameter int AW        = $clog2(MAX_DELAY)
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             cfg_load;
    logic [AW:0]      cfg_delay;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      cur_delay;
    logic [AW:0]      occupancy;
    logic             cfg_err;

    modport master (
        output in_valid,
        output in_data,
        output cfg_load,
        output cfg_delay,
        output flush,
        input  out_valid,
        input  out_data,
        input  cur_delay,
        input  occupancy,
        input  cfg_err
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  cfg_load,
        input  cfg_delay,
        input  flush,
        output out_valid,
        output out_data,
        output cur_delay,
        output occupancy,
        output cfg_err
    );
endinterface

// File: rtl/prog_delay_line.sv
// Programmable delay line: delays a valid-tagged sample stream by 1..MAX_DELAY
// cycles. Storage is a circular buffer. The write pointer advances every cycle,
// so gaps in the stream are preserved. The read slot sits cur_delay entries
// behind the write pointer.
module prog_delay_line #(
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 4,
    parameter int AW            = $clog2(MAX_DELAY)
) (
    input logic              clk,
    input logic              rst,
    prog_delay_line_if.slave bus
);
    localparam logic [AW:0] MAX_D = (AW+1)'(MAX_DELAY);
    localparam logic [AW:0] DEF_D = (AW+1)'(DEFAULT_DELAY);

    logic [WIDTH-1:0]     data_mem [MAX_DELAY];
    logic [MAX_DELAY-1:0] valid_bits;
    logic [MAX_DELAY-1:0] valid_next;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_idx;
    logic [AW:0]          delay_reg;
    logic [AW:0]          occ_reg;
    logic [AW:0]          occ_base;
    logic [AW:0]          occ_next;
    logic [WIDTH-1:0]     data_reg;
    logic                 valid_reg;
    logic                 err_reg;
    logic                 cfg_legal;
    logic                 cfg_apply;
    logic                 clear_all;
    logic                 rd_valid;

    // Decode configuration/flush, locate the read slot and form the next valid map and occupancy
    always_comb begin
        cfg_legal  = (bus.cfg_delay != '0) && (bus.cfg_delay <= MAX_D);
        cfg_apply  = bus.cfg_load && cfg_legal;
        clear_all  = cfg_apply || bus.flush;
        rd_idx     = wr_ptr - delay_reg[AW-1:0];
        rd_valid   = valid_bits[rd_idx] && !clear_all;
        valid_next = clear_all ? '0 : valid_bits;
        valid_next[wr_ptr] = bus.in_valid;
        occ_base   = clear_all ? '0 : occ_reg;
        occ_next   = occ_base + (AW+1)'(bus.in_valid) - (AW+1)'(rd_valid);
    end

    // Control state and registered outputs; a clear suppresses the sample leaving this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            valid_bits <= '0;
            delay_reg  <= DEF_D;
            occ_reg    <= '0;
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(1);
            valid_bits <= valid_next;
            occ_reg    <= occ_next;
            valid_reg  <= rd_valid;
            err_reg    <= bus.cfg_load && !cfg_legal;
            if (cfg_apply) begin
                delay_reg <= bus.cfg_delay;
            end
            if (rd_valid) begin
                data_reg <= data_mem[rd_idx];
            end
        end
    end

    // Data storage without reset; the read above sees the old word when D equals MAX_DELAY
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            data_mem[wr_ptr] <= bus.in_data;
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.out_data  = data_reg;
    assign bus.cur_delay = delay_reg;
    assign bus.occupancy = occ_reg;
    assign bus.cfg_err   = err_reg;
endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line. A history-based model predicts every
// output: a sample accepted at edge k emerges at edge k+D, unless a clear
// happened after k. Directed scenarios pin the model with literal values, and a
// long randomized run follows.
module tb_prog_delay_line;
    localparam int WIDTH         = 8;
    localparam int MAX_DELAY     = 16;
    localparam int DEFAULT_DELAY = 4;
    localparam int AW            = $clog2(MAX_DELAY);
    localparam int HIST          = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prog_delay_line_if #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) bus ();

    prog_delay_line #(
        .WIDTH(WIDTH),
        .MAX_DELAY(MAX_DELAY),
        .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    bit         checking = 1'b0;
    bit         release_pending = 1'b0;
    bit         hist_valid [HIST];
    logic [7:0] hist_data [HIST];
    int         edge_idx = 0;
    int         last_clear = 0;
    int         model_delay = DEFAULT_DELAY;
    bit         exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    bit         exp_err = 1'b0;
    int         exp_occ = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        exp_valid   = 1'b0;
        exp_data    = 8'h00;
        exp_err     = 1'b0;
        exp_occ     = 0;
        model_delay = DEFAULT_DELAY;
        last_clear  = edge_idx;
    endfunction

    task automatic model_edge(input bit v, input logic [7:0] d, input bit load,
                              input int cdel, input bit fl);
        bit legal;
        bit clr;
        int src;
        int lo;
        int j;
        j = edge_idx;
        if (j >= HIST) begin
            miscompares++;
            $display("[TB] FAIL history: got edge %0d, expected below %0d", j, HIST);
            $fatal(1, "[TB] history exhausted");
        end
        legal = (cdel >= 1) && (cdel <= MAX_DELAY);
        clr   = fl || (load && legal);
        src   = j - model_delay;
        exp_valid = 1'b0;
        if (!clr && src >= last_clear && src >= 0) begin
            exp_valid = hist_valid[src];
        end
        if (exp_valid) begin
            exp_data = hist_data[src];
        end
        exp_err = load && !legal;
        if (clr) begin
            last_clear = j;
        end
        if (load && legal) begin
            model_delay = cdel;
        end
        hist_valid[j] = v;
        hist_data[j]  = d;
        exp_occ = 0;
        lo = j - model_delay + 1;
        if (lo < last_clear) begin
            lo = last_clear;
        end
        for (int k = lo; k <= j; k++) begin
            if (hist_valid[k]) begin
                exp_occ++;
            end
        end
        edge_idx = j + 1;
    endtask

    task automatic apply_stimulus(input bit v, input logic [7:0] d, input bit load,
                                  input int cdel, input bit fl);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.cfg_load  = load;
        bus.cfg_delay = (AW+1)'(cdel);
        bus.flush     = fl;
        if (release_pending) begin
            rst = 1'b0;
            release_pending = 1'b0;
        end
        @(posedge clk);
        if (!rst) begin
            model_edge(v, d, load, cdel, fl);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 8'h00, 1'b0, 0, 1'b0);
    endtask

    task automatic load_delay(input int dv);
        apply_stimulus(1'b0, 8'h00, 1'b1, dv, 1'b0);
    endtask

    // Compare every output with the model on each falling edge
    always @(negedge clk) begin
        if (checking) begin
            check_output("out_valid", bus.out_valid, exp_valid);
            check_output("out_data", bus.out_data, exp_data);
            check_output("cur_delay", bus.cur_delay, model_delay);
            check_output("occupancy", bus.occupancy, exp_occ);
            check_output("cfg_err", bus.cfg_err, exp_err);
        end
    end

    int         sweep [4] = '{1, 2, 7, 16};
    bit   [6:0] sparse_pat = 7'b1011001;
    logic [7:0] sparse_data [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] got [8];
    logic [9:0] seen;

    initial begin
        int n_in;
        int n_out;
        bit v;
        bit load;
        bit fl;
        int cdel;
        int r;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.cfg_load  = 1'b0;
        bus.cfg_delay = '0;
        bus.flush     = 1'b0;
        model_reset();
        checking = 1'b1;

        // Reset/default: inputs ignored while in reset, then default delay of 4
        repeat (3) apply_stimulus(1'b1, 8'h11, 1'b0, 0, 1'b0);
        #1;
        check_output("reset_out_valid", bus.out_valid, 0);
        check_output("reset_occupancy", bus.occupancy, 0);
        check_output("reset_cur_delay", bus.cur_delay, 4);
        release_pending = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 8'(8'h11 + i), 1'b0, 0, 1'b0);
            #1;
            if (i == 4) begin
                check_output("first_emerge_valid", bus.out_valid, 1);
                check_output("first_emerge_data", bus.out_data, 8'h11);
            end
        end
        check_output("settled_occupancy", bus.occupancy, 4);

        // Reset mid-stream: asynchronous, pre-reset samples never emerge
        do_reset();
        #1;
        check_output("async_reset_valid", bus.out_valid, 0);
        check_output("async_reset_occupancy", bus.occupancy, 0);
        check_output("async_reset_data", bus.out_data, 0);
        apply_stimulus(1'b1, 8'h77, 1'b0, 0, 1'b0);
        release_pending = 1'b1;
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 8'(8'h80 + i), 1'b0, 0, 1'b0);
        idle(6);

        // Delay sweep with pointer wrap
        foreach (sweep[s]) begin
            load_delay(sweep[s]);
            for (int i = 0; i < 40; i++) begin
                apply_stimulus(1'b1, 8'(i + 1), 1'b0, 0, 1'b0);
                #1;
                if (i == sweep[s]) begin
                    check_output("sweep_first_valid", bus.out_valid, 1);
                    check_output("sweep_first_data", bus.out_data, 1);
                end
            end
            idle(sweep[s] + 2);
        end

        // Sparse traffic at D=3
        load_delay(3);
        n_in  = 0;
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            v = (i < 7) ? sparse_pat[i] : 1'b0;
            apply_stimulus(v, v ? sparse_data[n_in] : 8'h5F, 1'b0, 0, 1'b0);
            if (v) n_in++;
            #1;
            seen[i] = bus.out_valid;
            if (bus.out_valid && n_out < 8) begin
                got[n_out] = bus.out_data;
                n_out++;
            end
        end
        check_output("sparse_pattern", seen, 10'b1011001000);
        check_output("sparse_count", n_out, 4);
        check_output("sparse_data0", got[0], 8'hAA);
        check_output("sparse_data1", got[1], 8'hBB);
        check_output("sparse_data2", got[2], 8'hCC);
        check_output("sparse_data3", got[3], 8'hDD);

        // Reconfigure mid-stream with a sample on the load edge
        load_delay(8);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'h01 + i), 1'b0, 0, 1'b0);
        apply_stimulus(1'b1, 8'h5A, 1'b1, 2, 1'b0);
        #1;
        check_output("reload_cur_delay", bus.cur_delay, 2);
        check_output("reload_occupancy", bus.occupancy, 1);
        check_output("reload_out_valid", bus.out_valid, 0);
        idle(1);
        #1;
        check_output("reload_wait_valid", bus.out_valid, 0);
        check_output("reload_wait_occupancy", bus.occupancy, 1);
        idle(1);
        #1;
        check_output("reload_emerge_valid", bus.out_valid, 1);
        check_output("reload_emerge_data", bus.out_data, 8'h5A);
        check_output("reload_emerge_occupancy", bus.occupancy, 0);
        idle(10);

        // Illegal configuration values during streaming
        load_delay(5);
        for (int i = 0; i < 12; i++) begin
            load = (i == 4) || (i == 8);
            cdel = (i == 8) ? 17 : 0;
            apply_stimulus(1'b1, 8'(8'h30 + i), load, cdel, 1'b0);
            #1;
            if (load) check_output("illegal_err_pulse", bus.cfg_err, 1);
            if (i == 5 || i == 9) check_output("illegal_err_clear", bus.cfg_err, 0);
            if (i == 8) check_output("illegal_occupancy", bus.occupancy, 5);
            if (i == 9) check_output("illegal_cur_delay", bus.cur_delay, 5);
        end
        idle(7);

        // Flush on the edge that accepts 0xC3
        load_delay(6);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, (i == 9) ? 8'hC3 : 8'(8'h40 + i), 1'b0, 0, i == 9);
        end
        #1;
        check_output("flush_occupancy", bus.occupancy, 1);
        check_output("flush_cur_delay", bus.cur_delay, 6);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            #1;
            if (i < 5) check_output("flush_dropped", bus.out_valid, 0);
            else begin
                check_output("flush_emerge_valid", bus.out_valid, 1);
                check_output("flush_emerge_data", bus.out_data, 8'hC3);
            end
        end

        // Randomized traffic with configuration, flush and reset events
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset();
                apply_stimulus(1'b1, 8'($urandom), 1'b0, 0, 1'b0);
                release_pending = 1'b1;
            end else begin
                v    = ($urandom_range(0, 3) != 0);
                load = ($urandom_range(0, 99) < 3);
                cdel = $urandom_range(0, 20);
                fl   = ($urandom_range(0, 99) < 2);
                apply_stimulus(v, 8'($urandom), load, cdel, fl);
            end
        end
        idle(20);

        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
